// File: rtl/cmos_capture_pkg.sv
// cmos_capture_pkg: shared types, constants and helpers for the CMOS pixel capture block
package cmos_capture_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_FRAME, ACTIVE} state_e;
  localparam int SYNC_DEPTH = 2;
  function automatic logic [2:0] decim_mask(input logic [1:0] d);
    return 3'((4'd1 << d) - 4'd1);
  endfunction
endpackage

// File: rtl/cmos_sync_edge.sv
// cmos_sync_edge: multi-flop synchroniser with a history flop for rise/fall detection
module cmos_sync_edge
  import cmos_capture_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic [W-1:0] rise_o,
  output logic [W-1:0] fall_o
);
  logic [SYNC_DEPTH-1:0][W-1:0] sync_q;
  logic [W-1:0]                 hist_q;
  // shift raw pins through the synchroniser and keep the previous synced value
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], d_i};
      hist_q <= sync_q[SYNC_DEPTH-1];
    end
  end
  assign q_o    = sync_q[SYNC_DEPTH-1];
  assign rise_o = q_o & ~hist_q;
  assign fall_o = ~q_o & hist_q;
endmodule

// File: rtl/cmos_pixel_capture.sv
// cmos_pixel_capture: DVP sensor capture with crop, decimation and a one-entry valid/ready output
module cmos_pixel_capture
  import cmos_capture_pkg::*;
#(
  parameter int BPP   = 2,
  parameter int X_W   = 11,
  parameter int Y_W   = 10,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               single_shot,
  input  logic [X_W-1:0]     crop_x0,
  input  logic [X_W-1:0]     crop_x1,
  input  logic [Y_W-1:0]     crop_y0,
  input  logic [Y_W-1:0]     crop_y1,
  input  logic [1:0]         decim,
  input  logic               clear_status,
  input  logic               cmos_pclk,
  input  logic               cmos_href,
  input  logic               cmos_vsync,
  input  logic [7:0]         cmos_db,
  output logic [8*BPP-1:0]   m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_sof,
  output logic               m_eol,
  output logic               busy,
  output logic               frame_done,
  output logic               overflow,
  output logic [CNT_W-1:0]   drop_count,
  output logic [CNT_W-1:0]   frame_count
);
  logic [2:0]         ctl_s, ctl_r, ctl_f;
  logic [7:0]         db_s;
  state_e             state_q;
  logic [X_W-1:0]     x_q;
  logic [Y_W-1:0]     y_q;
  logic [1:0]         bidx_q;
  logic [8*BPP-1:0]   asm_q, m_data_q;
  logic               sof_pend_q, shot_done_q, m_valid_q, m_sof_q, m_eol_q, overflow_q, fdone_q;
  logic [CNT_W-1:0]   drop_q, fcount_q;
  logic [8*BPP+7:0]   shift;
  logic [8*BPP-1:0]   pix;
  logic [2:0]         dm;
  logic               pclk_rise, href_s, href_fall, vs_rise, vs_fall;
  logic               keep, byte_ev, pix_done, emit, load, drop;

  cmos_sync_edge #(.W(3)) u_ctl (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    ({cmos_pclk, cmos_href, cmos_vsync}),
    .q_o    (ctl_s),
    .rise_o (ctl_r),
    .fall_o (ctl_f)
  );

  cmos_sync_edge #(.W(8)) u_db (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (cmos_db),
    .q_o    (db_s),
    .rise_o (),
    .fall_o ()
  );

  assign pclk_rise = ctl_r[2];
  assign href_s    = ctl_s[1];
  assign href_fall = ctl_f[1];
  assign vs_rise   = ctl_r[0];
  assign vs_fall   = ctl_f[0];
  assign shift     = {asm_q, db_s};
  assign pix       = shift[8*BPP-1:0];
  assign dm        = decim_mask(decim);
  assign keep      = x_q >= crop_x0 && x_q <= crop_x1 && y_q >= crop_y0 && y_q <= crop_y1 &&
                     (x_q[2:0] & dm) == 3'd0 && (y_q[2:0] & dm) == 3'd0;
  assign byte_ev   = state_q == ACTIVE && !vs_rise && !href_fall && pclk_rise && href_s;
  assign pix_done  = byte_ev && bidx_q == 2'(BPP-1);
  assign emit      = pix_done && keep;
  assign load      = emit && (!m_valid_q || m_ready);
  assign drop      = emit && !load;

  // frame/line/byte sequencing, output register and status counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      bidx_q      <= '0;
      asm_q       <= '0;
      sof_pend_q  <= 1'b0;
      shot_done_q <= 1'b0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      m_sof_q     <= 1'b0;
      m_eol_q     <= 1'b0;
      overflow_q  <= 1'b0;
      drop_q      <= '0;
      fcount_q    <= '0;
      fdone_q     <= 1'b0;
    end else begin
      fdone_q <= 1'b0;
      if (!enable || !single_shot) shot_done_q <= 1'b0;
      if (m_valid_q && m_ready) m_valid_q <= 1'b0;
      if (load) begin
        m_data_q  <= pix;
        m_sof_q   <= sof_pend_q;
        m_eol_q   <= x_q == crop_x1;
        m_valid_q <= 1'b1;
      end
      if (emit) sof_pend_q <= 1'b0;
      if (clear_status) begin
        overflow_q <= 1'b0;
        drop_q     <= '0;
      end else if (drop) begin
        overflow_q <= 1'b1;
        if (~&drop_q) drop_q <= drop_q + CNT_W'(1);
      end
      case (state_q)
        IDLE: if (enable && !shot_done_q) state_q <= WAIT_FRAME;
        WAIT_FRAME:
          if (vs_fall) begin
            x_q        <= '0;
            y_q        <= '0;
            bidx_q     <= '0;
            sof_pend_q <= 1'b1;
            state_q    <= ACTIVE;
          end else if (!enable) state_q <= IDLE;
        ACTIVE:
          if (vs_rise) begin
            bidx_q   <= '0;
            fdone_q  <= 1'b1;
            fcount_q <= fcount_q + CNT_W'(1);
            state_q  <= (single_shot || !enable) ? IDLE : WAIT_FRAME;
            if (single_shot) shot_done_q <= 1'b1;
          end else if (href_fall) begin
            bidx_q <= '0;
            x_q    <= '0;
            if (x_q != '0) y_q <= y_q + Y_W'(1);
          end else if (byte_ev) begin
            asm_q  <= pix;
            bidx_q <= pix_done ? 2'd0 : bidx_q + 2'd1;
            if (pix_done) x_q <= x_q + X_W'(1);
          end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_data      = m_data_q;
  assign m_valid     = m_valid_q;
  assign m_sof       = m_sof_q;
  assign m_eol       = m_eol_q;
  assign busy        = state_q != IDLE;
  assign frame_done  = fdone_q;
  assign overflow    = overflow_q;
  assign drop_count  = drop_q;
  assign frame_count = fcount_q;
endmodule

// File: tb/tb_cmos_pixel_capture.sv
// tb_cmos_pixel_capture: scenario-driven scoreboard bench for cmos_pixel_capture
module tb_cmos_pixel_capture;
  localparam int BPP = 2, X_W = 11, Y_W = 10, CNT_W = 16;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, single_shot = 1'b0, clear_status = 1'b0, m_ready = 1'b1;
  logic [X_W-1:0] crop_x0 = '0, crop_x1 = 11'd5;
  logic [Y_W-1:0] crop_y0 = '0, crop_y1 = 10'd3;
  logic [1:0] decim = 2'd0;
  logic cmos_pclk = 1'b0, cmos_href = 1'b0, cmos_vsync = 1'b0;
  logic [7:0] cmos_db = 8'h00;
  logic [8*BPP-1:0] m_data;
  logic m_valid, m_sof, m_eol, busy, frame_done, overflow;
  logic [CNT_W-1:0] drop_count, frame_count;
  int checks = 0, errors = 0, n_out = 0, fd_cnt = 0;
  bit sb_on = 1'b1, exp_sof = 1'b0;
  logic [17:0] sb_q[$];
  logic [17:0] e;

  cmos_pixel_capture #(.BPP(BPP), .X_W(X_W), .Y_W(Y_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .single_shot(single_shot),
    .crop_x0(crop_x0), .crop_x1(crop_x1), .crop_y0(crop_y0), .crop_y1(crop_y1),
    .decim(decim), .clear_status(clear_status),
    .cmos_pclk(cmos_pclk), .cmos_href(cmos_href), .cmos_vsync(cmos_vsync), .cmos_db(cmos_db),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_sof(m_sof), .m_eol(m_eol),
    .busy(busy), .frame_done(frame_done), .overflow(overflow),
    .drop_count(drop_count), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // output monitor: every accepted pixel is popped from the scoreboard and compared
  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (m_valid && m_ready) begin
      n_out++;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_px: got data=%h sof=%b eol=%b, required no pixel", m_data, m_sof, m_eol);
      end else begin
        e = sb_q.pop_front();
        if ({m_data, m_sof, m_eol} !== e) begin
          errors++;
          $display("FAIL px: got data=%h sof=%b eol=%b, required data=%h sof=%b eol=%b",
                   m_data, m_sof, m_eol, e[17:2], e[1], e[0]);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic bit keep_px(input int x, input int y);
    int m;
    m = (1 << decim) - 1;
    return x >= int'(crop_x0) && x <= int'(crop_x1) && y >= int'(crop_y0) && y <= int'(crop_y1) &&
           (x & m) == 0 && (y & m) == 0;
  endfunction

  function automatic logic [15:0] px_val(input int x, input int y, input int mode);
    return mode == 0 ? 16'h1234 : mode == 1 ? {8'(y), 8'(x)} : {8'hA5, 8'(x)};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    cmos_db = b;
    cmos_pclk = 1'b0;
    tick(3);
    cmos_pclk = 1'b1;
    tick(3);
  endtask

  task automatic send_px(input int x, input int y, input int mode);
    logic [15:0] v;
    v = px_val(x, y, mode);
    send_byte(v[15:8]);
    cmos_db = v[7:0];
    cmos_pclk = 1'b0;
    tick(3);
    cmos_pclk = 1'b1;
    if (sb_on && keep_px(x, y)) begin
      sb_q.push_back({v, exp_sof, x == int'(crop_x1)});
      exp_sof = 1'b0;
    end
    tick(3);
  endtask

  task automatic vsync_fall();
    cmos_vsync = 1'b1;
    tick(4);
    cmos_vsync = 1'b0;
    exp_sof = 1'b1;
    tick(6);
  endtask

  task automatic vsync_rise();
    cmos_pclk = 1'b0;
    cmos_href = 1'b0;
    cmos_vsync = 1'b1;
    tick(8);
  endtask

  task automatic send_line(input int w, input int y, input int mode);
    cmos_href = 1'b1;
    tick(3);
    for (int x = 0; x < w; x++) send_px(x, y, mode);
    cmos_pclk = 1'b0;
    cmos_href = 1'b0;
    tick(6);
  endtask

  task automatic send_frame(input int w, input int h, input int mode);
    vsync_fall();
    for (int y = 0; y < h; y++) send_line(w, y, mode);
    vsync_rise();
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) tick(1);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d pixels outstanding, required 0", name, sb_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    checks += 4;
    if ({m_valid, m_sof, m_eol, busy, frame_done, overflow} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 000000", {m_valid, m_sof, m_eol, busy, frame_done, overflow});
    end
    if (m_data !== '0) begin errors++; $display("FAIL reset_data: got %h, required 0", m_data); end
    if (frame_count !== '0) begin errors++; $display("FAIL reset_fcount: got %0d, required 0", frame_count); end
    if (drop_count !== '0) begin errors++; $display("FAIL reset_drops: got %0d, required 0", drop_count); end
  endtask

  task automatic test_full_frame();
    int n0, f0;
    n0 = n_out;
    f0 = fd_cnt;
    enable = 1'b1;
    tick(2);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL full_busy: got %b, required 1", busy); end
    send_frame(6, 4, 0);
    wait_drain("full");
    checks += 3;
    if (n_out - n0 != 24) begin errors++; $display("FAIL full_count: got %0d, required 24", n_out - n0); end
    if (fd_cnt - f0 != 1) begin errors++; $display("FAIL full_fdone: got %0d, required 1", fd_cnt - f0); end
    if (frame_count !== 16'd1) begin errors++; $display("FAIL full_fcount: got %0d, required 1", frame_count); end
  endtask

  task automatic test_crop();
    int n0;
    n0 = n_out;
    crop_x0 = 11'd2; crop_x1 = 11'd3; crop_y0 = 10'd1; crop_y1 = 10'd2;
    send_frame(6, 4, 1);
    wait_drain("crop");
    checks += 2;
    if (n_out - n0 != 4) begin errors++; $display("FAIL crop_count: got %0d, required 4", n_out - n0); end
    if (frame_count !== 16'd2) begin errors++; $display("FAIL crop_fcount: got %0d, required 2", frame_count); end
  endtask

  task automatic test_decim();
    int n0;
    n0 = n_out;
    crop_x0 = 11'd0; crop_x1 = 11'd7; crop_y0 = 10'd0; crop_y1 = 10'd3; decim = 2'd1;
    send_frame(8, 4, 1);
    wait_drain("decim");
    decim = 2'd0;
    checks += 2;
    if (n_out - n0 != 8) begin errors++; $display("FAIL decim_count: got %0d, required 8", n_out - n0); end
    if (frame_count !== 16'd3) begin errors++; $display("FAIL decim_fcount: got %0d, required 3", frame_count); end
  endtask

  task automatic test_overflow();
    crop_x1 = 11'd5; crop_y1 = 10'd0;
    m_ready = 1'b0;
    sb_on = 1'b0;
    vsync_fall();
    send_line(6, 0, 2);
    checks += 4;
    if ({m_valid, m_sof} !== 2'b11) begin errors++; $display("FAIL ovf_hold: got valid,sof=%b, required 11", {m_valid, m_sof}); end
    if (m_data !== 16'hA500) begin errors++; $display("FAIL ovf_data: got %h, required a500", m_data); end
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b, required 1", overflow); end
    if (drop_count !== 16'd5) begin errors++; $display("FAIL ovf_drops: got %0d, required 5", drop_count); end
    vsync_rise();
    clear_status = 1'b1;
    tick(1);
    clear_status = 1'b0;
    checks += 2;
    if (overflow !== 1'b0) begin errors++; $display("FAIL clr_flag: got %b, required 0", overflow); end
    if (drop_count !== 16'd0) begin errors++; $display("FAIL clr_drops: got %0d, required 0", drop_count); end
    sb_q.push_back({16'hA500, 1'b1, 1'b0});
    sb_on = 1'b1;
    m_ready = 1'b1;
    wait_drain("ovf");
    tick(1);
    checks += 2;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %b, required 0", m_valid); end
    if (frame_count !== 16'd4) begin errors++; $display("FAIL ovf_fcount: got %0d, required 4", frame_count); end
  endtask

  task automatic test_single_shot();
    int n0, f0;
    n0 = n_out;
    f0 = fd_cnt;
    single_shot = 1'b1;
    crop_x1 = 11'd1;
    send_frame(2, 1, 2);
    tick(2);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL ss_busy1: got %b, required 0", busy); end
    sb_on = 1'b0;
    send_frame(2, 1, 2);
    send_frame(2, 1, 2);
    sb_on = 1'b1;
    wait_drain("ss");
    checks += 4;
    if (busy !== 1'b0) begin errors++; $display("FAIL ss_busy3: got %b, required 0", busy); end
    if (frame_count !== 16'd5) begin errors++; $display("FAIL ss_fcount: got %0d, required 5", frame_count); end
    if (n_out - n0 != 2) begin errors++; $display("FAIL ss_count: got %0d, required 2", n_out - n0); end
    if (fd_cnt - f0 != 1) begin errors++; $display("FAIL ss_fdone: got %0d, required 1", fd_cnt - f0); end
    single_shot = 1'b0;
    tick(3);
  endtask

  task automatic test_abort();
    int n0, f0;
    n0 = n_out;
    f0 = fd_cnt;
    crop_x1 = 11'd5; crop_y1 = 10'd3;
    vsync_fall();
    cmos_href = 1'b1;
    tick(3);
    send_byte(8'h11);
    vsync_rise();
    checks += 3;
    if (frame_count !== 16'd6) begin errors++; $display("FAIL part_fcount: got %0d, required 6", frame_count); end
    if (fd_cnt - f0 != 1) begin errors++; $display("FAIL part_fdone: got %0d, required 1", fd_cnt - f0); end
    if (n_out != n0) begin errors++; $display("FAIL part_count: got %0d, required 0", n_out - n0); end
    vsync_fall();
    cmos_href = 1'b1;
    tick(3);
    send_px(0, 0, 2);
    send_byte(8'hA5);
    rst_n = 1'b0;
    tick(1);
    checks += 4;
    if (sb_q.size() != 0) begin errors++; $display("FAIL rst_pending: got %0d, required 0", sb_q.size()); end
    if ({m_valid, m_sof, m_eol, busy, frame_done, overflow} !== 6'b0) begin
      errors++;
      $display("FAIL rst_flags: got %b, required 000000", {m_valid, m_sof, m_eol, busy, frame_done, overflow});
    end
    if (m_data !== '0) begin errors++; $display("FAIL rst_data: got %h, required 0", m_data); end
    if (frame_count !== '0 || drop_count !== '0) begin
      errors++;
      $display("FAIL rst_counts: got fc=%0d dc=%0d, required 0 0", frame_count, drop_count);
    end
    rst_n = 1'b1;
    sb_on = 1'b0;
    send_byte(8'h01);
    send_px(1, 0, 2);
    cmos_pclk = 1'b0;
    cmos_href = 1'b0;
    tick(4);
    vsync_rise();
    checks += 2;
    if (frame_count !== 16'd0) begin errors++; $display("FAIL rst_nofc: got %0d, required 0", frame_count); end
    if (busy !== 1'b1) begin errors++; $display("FAIL rst_wait: got %b, required 1", busy); end
    sb_on = 1'b1;
    n0 = n_out;
    crop_x1 = 11'd1; crop_y1 = 10'd0;
    send_frame(2, 1, 2);
    wait_drain("resume");
    checks += 2;
    if (n_out - n0 != 2) begin errors++; $display("FAIL resume_count: got %0d, required 2", n_out - n0); end
    if (frame_count !== 16'd1) begin errors++; $display("FAIL resume_fcount: got %0d, required 1", frame_count); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_crop();
    test_decim();
    test_overflow();
    test_single_shot();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cmos_pixel_capture.md
Name: cmos_pixel_capture

Overview:
Parametrised capture front-end for DVP-style CMOS sensors such as the OV7670. It runs entirely in the system clock domain: it oversamples pclk, href and vsync, assembles BPP bytes into each pixel, and applies a runtime crop window and power-of-two decimation. Pixels leave on a valid/ready stream with start-of-frame and end-of-line flags, which feeds the asyn_fifo/SDRAM path. Unlike the fixed RGB565 capture FSM, it supports single-shot mode, overflow accounting and a frame counter.

Parameters:
BPP, 2, bytes per pixel (1..4); first received byte lands in the MSBs of m_data.
X_W, 11, width of the column counter and crop_x0/crop_x1.
Y_W, 10, width of the row counter and crop_y0/crop_y1.
CNT_W, 16, width of drop_count and frame_count.

Ports:
clk  in  1  system clock (at least 4x pclk).
rst_n  in  1  reset, synchronous, active-low.
enable  in  1  level; capture allowed; sampled only at frame boundaries.
single_shot  in  1  1 = capture one frame, then return to IDLE.
crop_x0, crop_x1  in  X_W each  inclusive column window, in pixels.
crop_y0, crop_y1  in  Y_W each  inclusive row window.
decim  in  2  keep pixels whose x and y low decim bits are 0.
clear_status  in  1  pulse; clears overflow and drop_count.
cmos_pclk, cmos_href, cmos_vsync  in  1 each  raw sensor pins (async).
cmos_db  in  8  raw sensor data.
m_data  out  8*BPP  pixel.
m_valid  out  1  pixel held.
m_ready  in  1  consumer accepts when m_valid && m_ready.
m_sof  out  1  qualifies m_data: first emitted pixel of the frame.
m_eol  out  1  qualifies m_data: pixel at x == crop_x1.
busy  out  1  state != IDLE.
frame_done  out  1  one-cycle pulse per completed frame.
overflow  out  1  sticky pixel-drop flag.
drop_count  out  CNT_W  saturating count of dropped pixels.
frame_count  out  CNT_W  wrapping count of completed frames.

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters 0, synchronisers 0.
- Input sync: pclk, href, vsync and db pass through a 2-flop synchroniser, then one history flop.
  - Edges are detected between stage 2 and the history flop.
  - Data is taken from stage 2, aligned with the pclk edge.
- FSM IDLE:
  - -> WAIT_FRAME when enable=1.
- FSM WAIT_FRAME:
  - On vsync falling edge: clear x, y and byte_idx, set sof_pending=1, -> ACTIVE.
  - If enable=0: -> IDLE.
- FSM ACTIVE, on pclk rising edge with synced href=1:
  - Shift the byte into the assembly register and increment byte_idx.
  - When byte_idx == BPP-1: pixel complete, byte_idx=0, x++ (after the keep check).
- ACTIVE, on href falling edge:
  - Discard any partial pixel (byte_idx=0), x=0.
  - y++ only if x != 0.
- ACTIVE, on vsync rising edge (end of frame, may be mid-line):
  - Partial data is discarded.
  - frame_done pulses, frame_count increments.
  - If single_shot=1 or enable=0: -> IDLE; otherwise -> WAIT_FRAME.
- Keep rule: crop_x0 <= x <= crop_x1, crop_y0 <= y <= crop_y1, x[decim-1:0]==0 and y[decim-1:0]==0. decim=0 keeps all pixels.
  - If crop_x0 > crop_x1 or crop_y0 > crop_y1, nothing is emitted.
- Output register (one entry):
  - A kept pixel loads m_data/m_sof/m_eol and sets m_valid one cycle after the completing pclk edge, provided the register is empty or is being drained that same cycle (m_valid && m_ready).
  - Otherwise the pixel is dropped: overflow=1, drop_count++ (saturating at all-ones).
  - m_sof = sof_pending; sof_pending clears when a pixel is loaded or dropped.
  - The register holds stable while m_valid && !m_ready.
- clear_status coinciding with a drop: clear wins, overflow=0 and drop_count=0.
- Leaving ACTIVE does not flush m_valid; the held pixel remains until accepted.
- Crop and decim inputs are assumed static within a frame; changes take effect at the next sampled pixel.
- rst_n=0 mid-frame aborts immediately; after release the block waits for a fresh vsync falling edge.

Decomposition:
- Package cmos_capture_pkg:
  - state enum (IDLE, WAIT_FRAME, ACTIVE)
  - sync depth constant (2)
  - function for the decimation mask
- Sub-module cmos_sync_edge: parametrised-width 2-flop synchroniser plus history flop, with rise/fall outputs. It is instantiated once for {pclk, href, vsync} and reused for db (data only).

Test Plan:
- Frame of 4 lines x 6 px, BPP=2, bytes 0x12,0x34 per px, full crop, decim=0, m_ready=1 -> 24 px of 0x1234; m_sof on the 1st only; m_eol on every 6th; frame_done=1 once; frame_count=1.
- Crop x 2..3, y 1..2, decim=0 on a 6x4 frame with px value = {y,x} -> 4 px in order (1,2),(1,3),(2,2),(2,3); m_sof on (1,2); m_eol on (1,3) and (2,3).
- decim=1 on an 8x4 frame, full crop -> 8 px, all with even x and even y; count exactly 8.
- m_ready=0 for a 6-px line -> first px held stable; 5 drops; overflow=1; drop_count=5; clear_status pulse -> both return to 0.
- single_shot=1 with 3 vsync cycles -> only frame 1 emitted; busy falls after first vsync rise; frame_count=1.
- vsync rising after 1 byte of a pixel, then rst_n=0 for 1 cycle mid-next-frame -> no partial pixel emitted; all outputs 0; resumes only after next vsync fall.
